// File: rtl/oc8051_cxrom_arb_pkg.sv
// Shared types and constants for the two-port code-ROM read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package oc8051_cxrom_arb_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 32;
  localparam int LOCK_MAX_DEF = 16;
  // Wide enough for the full 1..255 lock-limit range.
  localparam int CNT_W        = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

endpackage

// File: rtl/oc8051_cxrom_arb_pick.sv
// Winner select between the CPU fetch port (A) and the boot-hash port (B).
// Latency: purely combinational.
// Backpressure: none; the losing port stays eligible and is retried next cycle.
module oc8051_cxrom_arb_pick
  import oc8051_cxrom_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic             a_elig,
  input  logic             b_elig,
  input  port_id_t         last_grant,
  input  logic             b_lock,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic             grant_vld,
  output port_id_t         grant_port
);

  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

  // Single eligible port wins outright; contention uses the lock limit or
  // round-robin.
  always_comb begin
    grant_vld  = a_elig | b_elig;
    grant_port = PORT_A;
    if (a_elig && b_elig) begin
      if (b_lock) begin
        // B streams until it has used up its lock budget, then A gets one slot.
        grant_port = (lock_cnt == LOCK_LIMIT) ? PORT_A : PORT_B;
      end else begin
        grant_port = (last_grant == PORT_B) ? PORT_A : PORT_B;
      end
    end else if (b_elig) begin
      grant_port = PORT_B;
    end
  end

endmodule

// File: rtl/oc8051_cxrom_arb.sv
// Arbitrates two read requesters onto one external combinational code ROM.
// Latency: ack and data one cycle after the issue cycle.
// Backpressure: req held until ack; a port is ineligible in its own ack cycle.
module oc8051_cxrom_arb
  import oc8051_cxrom_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_data,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_lock,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] cxrom_addr,
  input  logic [DATA_W-1:0] cxrom_data_in
);

  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

  logic             a_elig;
  logic             b_elig;
  logic             grant_vld;
  logic             grant_a;
  logic             grant_b;
  port_id_t         grant_port;
  port_id_t         last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic [ADDR_W-1:0] held_addr;

  // A port whose ack is showing is finishing its access and cannot re-issue.
  assign a_elig  = a_req & ~a_ack;
  assign b_elig  = b_req & ~b_ack;
  assign grant_a = grant_vld && (grant_port == PORT_A);
  assign grant_b = grant_vld && (grant_port == PORT_B);

  oc8051_cxrom_arb_pick #(
    .LOCK_MAX (LOCK_MAX)
  ) u_pick (
    .a_elig     (a_elig),
    .b_elig     (b_elig),
    .last_grant (last_grant),
    .b_lock     (b_lock),
    .lock_cnt   (lock_cnt),
    .grant_vld  (grant_vld),
    .grant_port (grant_port)
  );

  // The ROM sees the winner's address in an issue cycle, else the last one.
  assign cxrom_addr = grant_a ? a_addr :
                      grant_b ? b_addr : held_addr;

  // Capture ROM data for the winner and pulse its ack for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_data     <= '0;
      b_data     <= '0;
      held_addr  <= '0;
      last_grant <= PORT_B;
    end else begin
      a_ack <= grant_a;
      b_ack <= grant_b;
      if (grant_vld) begin
        held_addr  <= cxrom_addr;
        last_grant <= grant_port;
      end
      if (grant_a) begin
        a_data <= cxrom_data_in;
      end
      if (grant_b) begin
        b_data <= cxrom_data_in;
      end
    end
  end

  // Count B grants that locked A out; any A grant or dropped lock resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (!b_lock || grant_a) begin
      lock_cnt <= '0;
    end else if (grant_b && a_elig && (lock_cnt != LOCK_LIMIT)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Self-checking bench for the code-ROM arbiter: per-cycle vector table,
// then scoreboard-checked streaming, lock-limit and lock-priority sequences.
// The ROM is modelled combinationally from cxrom_addr.
module tb_oc8051_cxrom_arb;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic [15:0] a_addr;
  logic        a_ack;
  logic [31:0] a_data;
  logic        b_req;
  logic [15:0] b_addr;
  logic        b_lock;
  logic        b_ack;
  logic [31:0] b_data;
  logic [15:0] cxrom_addr;
  logic [31:0] cxrom_data_in;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        a_req;
    logic [15:0] a_addr;
    logic        b_req;
    logic [15:0] b_addr;
    logic        b_lock;
    logic        ea;
    logic        eb;
    logic [15:0] ecx;
    logic [31:0] ead;
    logic [31:0] ebd;
  } vec_t;

  typedef struct {
    logic        is_b;
    logic [31:0] data;
  } sb_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  sb_t  sbq [$];

  function automatic logic [31:0] rom_f(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {~a, a};
  endfunction

  assign cxrom_data_in = rom_f(cxrom_addr);

  oc8051_cxrom_arb #(
    .LOCK_MAX (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a_req         (a_req),
    .a_addr        (a_addr),
    .a_ack         (a_ack),
    .a_data        (a_data),
    .b_req         (b_req),
    .b_addr        (b_addr),
    .b_lock        (b_lock),
    .b_ack         (b_ack),
    .b_data        (b_data),
    .cxrom_addr    (cxrom_addr),
    .cxrom_data_in (cxrom_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare any ack seen this cycle against the oldest predicted grant.
  task automatic sb_check();
    sb_t e;
    chk("no_dual_ack", 32'(a_ack & b_ack), 32'd0);
    if (a_ack || b_ack) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_ack", 32'(b_ack), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_port", 32'(b_ack), 32'(e.is_b));
        chk("sb_data", b_ack ? b_data : a_data, e.data);
      end
    end
  endtask

  task automatic cyc_sb();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  // Both ports request back to back; B is expected first, then strict alternation.
  task automatic run_stream(input logic lock, input logic [15:0] abase, input logic [15:0] bbase);
    int ac;
    int bc;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back('{1'b1, rom_f(16'(bbase + 16'(i)))});
      sbq.push_back('{1'b0, rom_f(16'(abase + 16'(i)))});
    end
    ac = 0;
    bc = 0;
    a_req = 1'b1; a_addr = abase;
    b_req = 1'b1; b_addr = bbase; b_lock = lock;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      sb_check();
      if (k >= 1 && k <= 12) chk("stream_ack_every_cycle", 32'(a_ack | b_ack), 32'd1);
      @(posedge clk);
      #1;
      if (a_ack) begin
        ac++;
        a_addr = a_addr + 16'd1;
        if (ac == 6) a_req = 1'b0;
      end
      if (b_ack) begin
        bc++;
        b_addr = b_addr + 16'd1;
        if (bc == 6) b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_addr = '0; b_lock = 1'b0;

    // chk rst ar aaddr br baddr bl | a_ack b_ack cxrom_addr a_data b_data
    tbl[0]  = '{0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 32'h0};
    tbl[1]  = '{1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 32'h0, 32'h0};
    tbl[2]  = '{1, 0, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 16'h0010, 32'h0, 32'h0};
    tbl[3]  = '{1, 0, 1, 16'h0010, 0, 16'h0000, 0, 1, 0, 16'h0010, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1, 0, 0, 16'h0010, 0, 16'h0000, 0, 0, 0, 16'h0010, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{0, 1, 1, 16'h0020, 1, 16'h0030, 0, 0, 0, 16'h0000, 32'h0, 32'h0};
    tbl[6]  = '{1, 1, 1, 16'h0020, 1, 16'h0030, 0, 0, 0, 16'h0020, 32'h0, 32'h0};
    tbl[7]  = '{1, 0, 1, 16'h0020, 1, 16'h0030, 0, 0, 0, 16'h0020, 32'h0, 32'h0};
    tbl[8]  = '{1, 0, 1, 16'h0020, 1, 16'h0030, 0, 1, 0, 16'h0030, 32'hFFDF0020, 32'h0};
    tbl[9]  = '{1, 0, 0, 16'h0020, 1, 16'h0030, 0, 0, 1, 16'h0030, 32'hFFDF0020, 32'hFFCF0030};
    tbl[10] = '{1, 1, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 16'h0040, 32'hFFDF0020, 32'hFFCF0030};
    tbl[11] = '{1, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 16'h0040, 32'h0, 32'h0};
    tbl[12] = '{1, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 1, 16'h0040, 32'h0, 32'hFFBF0040};
    tbl[13] = '{1, 0, 1, 16'h1234, 0, 16'h0040, 0, 0, 0, 16'h1234, 32'h0, 32'hFFBF0040};
    tbl[14] = '{1, 0, 1, 16'h1234, 0, 16'h0040, 0, 1, 0, 16'h1234, 32'hEDCB1234, 32'hFFBF0040};
    tbl[15] = '{1, 0, 0, 16'h1234, 0, 16'h0040, 0, 0, 0, 16'h1234, 32'hEDCB1234, 32'hFFBF0040};
    tbl[16] = '{1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h1234, 32'hEDCB1234, 32'hFFBF0040};

    for (int i = 0; i < NV; i++) begin
      rst    = tbl[i].rst;
      a_req  = tbl[i].a_req;
      a_addr = tbl[i].a_addr;
      b_req  = tbl[i].b_req;
      b_addr = tbl[i].b_addr;
      b_lock = tbl[i].b_lock;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_a_ack", i), 32'(a_ack), 32'(tbl[i].ea));
        chk($sformatf("v%0d_b_ack", i), 32'(b_ack), 32'(tbl[i].eb));
        chk($sformatf("v%0d_cxrom_addr", i), 32'(cxrom_addr), 32'(tbl[i].ecx));
        chk($sformatf("v%0d_a_data", i), a_data, tbl[i].ead);
        chk($sformatf("v%0d_b_data", i), b_data, tbl[i].ebd);
      end
      @(posedge clk);
      #1;
    end

    // Round-robin streaming without lock: one ack per cycle, B,A,B,A...
    run_stream(1'b0, 16'h0100, 16'h0200);

    // Lock limit: A withdraws during each B ack so only B lock wins accumulate.
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    cyc_sb();
    for (int i = 0; i < 4; i++) begin
      a_req = 1'b1; a_addr = 16'h0400;
      b_req = 1'b1; b_addr = 16'(16'h0300 + 16'(i)); b_lock = 1'b1;
      sbq.push_back('{1'b1, rom_f(b_addr)});
      cyc_sb();
      a_req = 1'b0; b_req = 1'b0;
      cyc_sb();
    end
    // Budget of four spent: A must win this contention despite the lock.
    a_req = 1'b1; a_addr = 16'h0400;
    b_req = 1'b1; b_addr = 16'h0304;
    sbq.push_back('{1'b0, rom_f(16'h0400)});
    cyc_sb();
    a_req = 1'b0;
    sbq.push_back('{1'b1, rom_f(16'h0304)});
    cyc_sb();
    b_req = 1'b0;
    cyc_sb();
    cyc_sb();
    b_lock = 1'b0;

    // Locked streaming: last grant was B, so only the lock makes B win first.
    run_stream(1'b1, 16'h0500, 16'h0600);

    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
